// File: rtl/uart_frame_dump_ctrl.sv
// Streams one captured frame out over the UART: sync header A5 5A, then each
// 16-bit pixel high byte first, with byte pacing taken from the transmitter's done pulse.
module uart_frame_dump_ctrl #(
   parameter int          FRAME_PIXELS = 307200,
   parameter int          CNT_W        = 19,
   parameter logic [7:0]  CMD_START    = 8'h53,
   parameter logic [7:0]  CMD_ABORT    = 8'h58,
   parameter logic [7:0]  SYNC0        = 8'hA5,
   parameter logic [7:0]  SYNC1        = 8'h5A
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_valid,
   output logic             o_pix_load,
   output logic             o_pix_req,
   input  logic [15:0]      i_pix_data,
   output logic             o_tx_start,
   output logic [7:0]       o_tx_byte,
   input  logic             i_tx_done,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_pix_count,
   output logic             o_done
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_S0,
      ST_S0_W,
      ST_S1,
      ST_S1_W,
      ST_REQ,
      ST_LATCH,
      ST_HI,
      ST_HI_W,
      ST_LO,
      ST_LO_W,
      ST_FIN
   } state_t;

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(FRAME_PIXELS);

   state_t           r_state;
   state_t           w_next;
   logic             r_abort;
   logic [15:0]      r_pix;
   logic [7:0]       r_tx_byte;
   logic [CNT_W-1:0] r_pix_count;

   logic             w_busy;
   logic             w_start_cmd;
   logic             w_abort_cmd;
   logic             w_abort;
   logic [CNT_W-1:0] w_count_inc;
   logic             w_tx_start;
   logic [7:0]       w_tx_sel;
   logic             w_pix_req;
   logic             w_pix_load;
   logic             w_latch;
   logic             w_count_clr;
   logic             w_count_en;

   assign w_busy      = (r_state != ST_IDLE) && (r_state != ST_FIN);
   assign w_start_cmd = i_rx_valid && (i_rx_data == CMD_START);
   assign w_abort_cmd = i_rx_valid && (i_rx_data == CMD_ABORT) && w_busy;
   // A fresh abort byte acts in the same cycle, so it can suppress that cycle's request.
   assign w_abort     = r_abort || w_abort_cmd;
   assign w_count_inc = r_pix_count + 1'b1;

   always_comb begin
      w_next      = r_state;
      w_tx_start  = 1'b0;
      w_tx_sel    = r_tx_byte;
      w_pix_req   = 1'b0;
      w_pix_load  = 1'b0;
      w_latch     = 1'b0;
      w_count_clr = 1'b0;
      w_count_en  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_cmd) w_next = ST_LOAD;
         end
         ST_LOAD: begin
            w_pix_load  = 1'b1;
            w_count_clr = 1'b1;
            w_next      = w_abort ? ST_IDLE : ST_S0;
         end
         ST_S0: begin
            if (w_abort) begin
               w_next = ST_IDLE;
            end else begin
               w_tx_start = 1'b1;
               w_tx_sel   = SYNC0;
               w_next     = ST_S0_W;
            end
         end
         ST_S0_W: begin
            if (i_tx_done) w_next = w_abort ? ST_IDLE : ST_S1;
         end
         ST_S1: begin
            if (w_abort) begin
               w_next = ST_IDLE;
            end else begin
               w_tx_start = 1'b1;
               w_tx_sel   = SYNC1;
               w_next     = ST_S1_W;
            end
         end
         ST_S1_W: begin
            if (i_tx_done) w_next = w_abort ? ST_IDLE : ST_REQ;
         end
         ST_REQ: begin
            if (w_abort) begin
               w_next = ST_IDLE;
            end else begin
               w_pix_req = 1'b1;
               w_next    = ST_LATCH;
            end
         end
         ST_LATCH: begin
            if (w_abort) begin
               w_next = ST_IDLE;
            end else begin
               w_latch = 1'b1;
               w_next  = ST_HI;
            end
         end
         ST_HI: begin
            if (w_abort) begin
               w_next = ST_IDLE;
            end else begin
               w_tx_start = 1'b1;
               w_tx_sel   = r_pix[15:8];
               w_next     = ST_HI_W;
            end
         end
         ST_HI_W: begin
            if (i_tx_done) w_next = w_abort ? ST_IDLE : ST_LO;
         end
         ST_LO: begin
            if (w_abort) begin
               w_next = ST_IDLE;
            end else begin
               w_tx_start = 1'b1;
               w_tx_sel   = r_pix[7:0];
               w_next     = ST_LO_W;
            end
         end
         ST_LO_W: begin
            // The pixel counts as sent even if an abort arrives with its final done pulse.
            if (i_tx_done) begin
               w_count_en = 1'b1;
               if (w_abort)                        w_next = ST_IDLE;
               else if (w_count_inc == LAST_COUNT) w_next = ST_FIN;
               else                                w_next = ST_REQ;
            end
         end
         ST_FIN: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)                   r_abort <= 1'b0;
      else if (w_next == ST_IDLE)  r_abort <= 1'b0;
      else if (w_abort_cmd)        r_abort <= 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)        r_pix <= 16'h0000;
      else if (w_latch) r_pix <= i_pix_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)           r_tx_byte <= 8'h00;
      else if (w_tx_start) r_tx_byte <= w_tx_sel;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)            r_pix_count <= '0;
      else if (w_count_clr) r_pix_count <= '0;
      else if (w_count_en)  r_pix_count <= w_count_inc;
   end

   assign o_pix_load  = w_pix_load;
   assign o_pix_req   = w_pix_req;
   assign o_tx_start  = w_tx_start;
   assign o_tx_byte   = w_tx_sel;
   assign o_busy      = w_busy;
   assign o_pix_count = r_pix_count;
   assign o_done      = (r_state == ST_FIN);

endmodule

// File: tb/tb_uart_frame_dump_ctrl.sv
// Bench for uart_frame_dump_ctrl with a 4-pixel frame, a FIFO model and a UART tx model;
// transmitted bytes are matched against a queue of required bytes by a monitor.
module tb_uart_frame_dump_ctrl;

   localparam int FP    = 4;
   localparam int CNT_W = 19;

   logic             clk      = 1'b0;
   logic             rst      = 1'b1;
   logic [7:0]       rxData   = 8'h00;
   logic             rxValid  = 1'b0;
   logic             pixLoad;
   logic             pixReq;
   logic [15:0]      pixData  = 16'h0000;
   logic             txStart;
   logic [7:0]       txByte;
   logic             txDone;
   logic             busy;
   logic [CNT_W-1:0] pixCount;
   logic             done;

   logic             modelDone = 1'b0;
   logic             spurDone  = 1'b0;
   int               txCnt     = 0;
   int               fifoIdx   = 0;
   logic [15:0]      fifoMem [4];

   int               total = 0;
   int               bad   = 0;
   logic [7:0]       expQ [$];
   logic [7:0]       monExp;
   int               cyc = 0;
   int               pixReqCnt = 0, loadCnt = 0, doneCnt = 0, txStartCnt = 0;
   int               lastTxDoneCyc = 0, doneCyc = 0;
   int               startCyc, baseReq, baseLoad, baseDone, baseTx;

   assign txDone = modelDone | spurDone;

   uart_frame_dump_ctrl #(
      .FRAME_PIXELS(FP),
      .CNT_W(CNT_W)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_rx_data(rxData),
      .i_rx_valid(rxValid),
      .o_pix_load(pixLoad),
      .o_pix_req(pixReq),
      .i_pix_data(pixData),
      .o_tx_start(txStart),
      .o_tx_byte(txByte),
      .i_tx_done(txDone),
      .o_busy(busy),
      .o_pix_count(pixCount),
      .o_done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO answers each request with the next word one cycle later.
   always @(posedge clk) begin
      if (pixLoad) begin
         fifoIdx <= 0;
      end else if (pixReq) begin
         pixData <= fifoMem[fifoIdx[1:0]];
         fifoIdx <= fifoIdx + 1;
      end
   end

   // UART tx model: done pulse 10 cycles after each start.
   always @(posedge clk) begin
      if (rst) begin
         txCnt     <= 0;
         modelDone <= 1'b0;
      end else begin
         modelDone <= 1'b0;
         if (txStart) begin
            txCnt <= 9;
         end else if (txCnt != 0) begin
            txCnt <= txCnt - 1;
            if (txCnt == 1) modelDone <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (txStart) begin
         txStartCnt++;
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL txByte: unexpected tx_start carrying %h, no byte required", txByte);
         end else begin
            monExp = expQ.pop_front();
            if (txByte !== monExp) begin
               bad++;
               $display("[TB] FAIL txByte: got %h required %h", txByte, monExp);
            end
         end
      end
      if (pixReq)  pixReqCnt++;
      if (pixLoad) loadCnt++;
      if (txDone)  lastTxDoneCyc = cyc;
      if (done) begin
         doneCnt++;
         doneCyc = cyc;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      tick();
      rxData  = b;
      rxValid = 1'b1;
      tick();
      rxValid = 1'b0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_pixLoad"},  32'(pixLoad),  32'd0);
      checkOutput({tag, "_pixReq"},   32'(pixReq),   32'd0);
      checkOutput({tag, "_txStart"},  32'(txStart),  32'd0);
      checkOutput({tag, "_txByte"},   32'(txByte),   32'd0);
      checkOutput({tag, "_busy"},     32'(busy),     32'd0);
      checkOutput({tag, "_pixCount"}, 32'(pixCount), 32'd0);
      checkOutput({tag, "_done"},     32'(done),     32'd0);
   endtask

   task automatic waitTxStarts(input int n, input string name);
      int seen = 0;
      int k    = 0;
      while (seen < n && k < 500) begin
         @(negedge clk);
         k++;
         if (txStart) seen++;
      end
      if (seen < n) checkOutput(name, 32'(seen), 32'(n));
   endtask

   task automatic waitTxDones(input int n, input string name);
      int seen = 0;
      int k    = 0;
      while (seen < n && k < 500) begin
         @(negedge clk);
         k++;
         if (txDone) seen++;
      end
      if (seen < n) checkOutput(name, 32'(seen), 32'(n));
   endtask

   task automatic waitDone(input string name);
      int k = 0;
      while (!done && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (!done) checkOutput(name, 32'd0, 32'd1);
   endtask

   task automatic snapshot();
      baseReq  = pixReqCnt;
      baseLoad = loadCnt;
      baseDone = doneCnt;
      baseTx   = txStartCnt;
   endtask

   initial begin
      fifoMem[0] = 16'h1234;
      fifoMem[1] = 16'hABCD;
      fifoMem[2] = 16'h0001;
      fifoMem[3] = 16'hFF00;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkResetOutputs("reset");

      // Full dump with start latency, spurious done in REQ and an ignored mid-dump 'S'.
      $display("[TB] basic dump");
      snapshot();
      expQ = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00};
      tick();
      rxData   = 8'h53;
      rxValid  = 1'b1;
      startCyc = cyc;
      @(negedge clk);
      checkOutput("loadBeforeLatency", 32'(pixLoad), 32'd0);
      tick();
      rxValid = 1'b0;
      @(negedge clk);
      checkOutput("loadLatency", 32'(pixLoad), 32'd1);
      checkOutput("busyInLoad", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("syncLatency", 32'(txStart), 32'd1);
      checkOutput("syncCycle", 32'(cyc - startCyc), 32'd2);
      waitTxDones(4, "waitPixel1");
      tick();
      spurDone = 1'b1;
      @(negedge clk);
      checkOutput("reqDuringSpurDone", 32'(pixReq), 32'd1);
      tick();
      spurDone = 1'b0;
      applyStimulus(8'h53);
      waitDone("basicDoneTimeout");
      checkOutput("busyAtFin", 32'(busy), 32'd0);
      tick();
      checkOutput("basicReqCount", 32'(pixReqCnt - baseReq), 32'd4);
      checkOutput("basicLoadCount", 32'(loadCnt - baseLoad), 32'd1);
      checkOutput("basicDoneCount", 32'(doneCnt - baseDone), 32'd1);
      checkOutput("basicPixCount", 32'(pixCount), 32'd4);
      checkOutput("doneLatency", 32'(doneCyc - lastTxDoneCyc), 32'd1);
      checkOutput("basicQueueEmpty", 32'(expQ.size()), 32'd0);
      @(negedge clk);
      checkOutput("busyAfterFin", 32'(busy), 32'd0);

      // Abort while the high byte of pixel 2 is in flight.
      $display("[TB] abort in HI_W");
      snapshot();
      expQ = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'hAB};
      applyStimulus(8'h53);
      waitTxStarts(5, "waitHiPixel2");
      tick();
      rxData  = 8'h58;
      rxValid = 1'b1;
      tick();
      rxValid = 1'b0;
      waitTxDones(1, "waitHiDone");
      @(negedge clk);
      checkOutput("abortIdle", 32'(busy), 32'd0);
      repeat (20) tick();
      checkOutput("abortPixCount", 32'(pixCount), 32'd1);
      checkOutput("abortNoDone", 32'(doneCnt - baseDone), 32'd0);
      checkOutput("abortReqCount", 32'(pixReqCnt - baseReq), 32'd2);
      checkOutput("abortTxCount", 32'(txStartCnt - baseTx), 32'd5);
      checkOutput("abortQueueEmpty", 32'(expQ.size()), 32'd0);

      // Restart after abort, then reset during LO_W of pixel 1.
      $display("[TB] restart and reset mid-dump");
      expQ = '{8'hA5, 8'h5A, 8'h12, 8'h34};
      applyStimulus(8'h53);
      @(negedge clk);
      checkOutput("restartLoad", 32'(pixLoad), 32'd1);
      waitTxStarts(4, "waitLoPixel1");
      checkOutput("restartCount", 32'(pixCount), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkResetOutputs("midReset");
      snapshot();
      repeat (40) tick();
      checkOutput("resetNoTx", 32'(txStartCnt - baseTx), 32'd0);
      checkOutput("resetNoReq", 32'(pixReqCnt - baseReq), 32'd0);
      checkOutput("resetQueueEmpty", 32'(expQ.size()), 32'd0);

      // 'X' and an unrelated byte in IDLE do nothing.
      $display("[TB] ignored bytes in idle");
      snapshot();
      applyStimulus(8'h58);
      applyStimulus(8'h41);
      repeat (20) tick();
      checkOutput("idleNoLoad", 32'(loadCnt - baseLoad), 32'd0);
      checkOutput("idleNoTx", 32'(txStartCnt - baseTx), 32'd0);
      checkOutput("idleNotBusy", 32'(busy), 32'd0);

      // Abort on the same cycle as the final done of pixel 3.
      $display("[TB] abort with tx_done in LO_W");
      snapshot();
      expQ = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
      applyStimulus(8'h53);
      waitTxStarts(8, "waitLoPixel3");
      repeat (10) @(posedge clk);
      #1;
      rxData  = 8'h58;
      rxValid = 1'b1;
      @(negedge clk);
      checkOutput("simulDoneAligned", 32'(txDone), 32'd1);
      tick();
      rxValid = 1'b0;
      @(negedge clk);
      checkOutput("simulIdle", 32'(busy), 32'd0);
      checkOutput("simulNoReq", 32'(pixReq), 32'd0);
      checkOutput("simulPixCount", 32'(pixCount), 32'd3);
      repeat (20) tick();
      checkOutput("simulReqCount", 32'(pixReqCnt - baseReq), 32'd3);
      checkOutput("simulNoDone", 32'(doneCnt - baseDone), 32'd0);
      checkOutput("simulTxCount", 32'(txStartCnt - baseTx), 32'd8);
      checkOutput("simulQueueEmpty", 32'(expQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/uart_frame_dump_ctrl.md
# uart_frame_dump_ctrl

Sequencer that streams one captured frame out over the board UART. A command byte from the UART receiver starts a dump. The block then reloads the frame-buffer read port, sends a 2-byte sync header, and fetches 16-bit pixels one at a time. Each pixel goes to the UART transmitter as two bytes (high byte first), with byte pacing set by the transmitter's done pulse. It sits between uart_rx/uart_tx and a dedicated SDRAM read FIFO port; it replaces ad-hoc trmt/tx_data wiring.

## Interface
- FRAME_PIXELS, 307200, pixels per dump (640*480)
- CNT_W, 19, width of pixel counter; must hold FRAME_PIXELS
- CMD_START, 8'h53, command byte that starts a dump ('S')
- CMD_ABORT, 8'h58, command byte that aborts a dump ('X')
- SYNC0, 8'hA5, first header byte
- SYNC1, 8'h5A, second header byte
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  synchronous active-high reset
- rx_data  in  8  received byte (uart_rx po_data)
- rx_valid  in  1  one-cycle strobe, rx_data valid (uart_rx po_flag)
- pix_load  out  1  one-cycle pulse reloading the read FIFO start address
- pix_req  out  1  one-cycle read request to the frame FIFO
- pix_data  in  16  pixel word, valid the cycle after pix_req
- tx_start  out  1  one-cycle pulse starting a UART byte (uart_tx trmt)
- tx_byte  out  8  byte to transmit; held stable from tx_start until tx_done
- tx_done  in  1  one-cycle pulse, current byte fully shifted out
- busy  out  1  high from LOAD through final byte completion
- pix_count  out  CNT_W  pixels fully transmitted in the current/last dump
- done  out  1  one-cycle pulse on successful dump completion

## Operation
- States: IDLE, LOAD, S0, S0_W, S1, S1_W, REQ, LATCH, HI, HI_W, LO, LO_W, FIN.
- IDLE: rx_valid with rx_data==CMD_START -> LOAD. All other bytes are ignored.
- LOAD: pix_load=1, pix_count cleared to 0 -> S0.
- S0: tx_start=1, tx_byte=SYNC0 -> S0_W. S0_W: on tx_done -> S1.
- S1: tx_start=1, tx_byte=SYNC1 -> S1_W. S1_W: on tx_done -> REQ.
- REQ: pix_req=1 -> LATCH. LATCH: register pix_data into a 16-bit pixel holding register -> HI.
- HI: tx_start=1, tx_byte=pix[15:8] -> HI_W. HI_W: on tx_done -> LO.
- LO: tx_start=1, tx_byte=pix[7:0] -> LO_W.
- LO_W: on tx_done, pix_count+=1. Then FIN if the new count == FRAME_PIXELS, else REQ.
- FIN: done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE and FIN.
- tx_byte holds its last value in all other states. It changes only in cycles where tx_start=1.
- Abort: rx_valid with CMD_ABORT while busy sets an internal abort flag.
  - Flag set in a state with no byte in flight (LOAD, S0, S1, REQ, LATCH, HI, LO): next state is IDLE, and the tx_start/pix_req of that cycle are suppressed.
  - Flag set in a *_W state: the state waits for tx_done, then goes to IDLE.
  - An abort never truncates a UART byte and never pulses done. pix_count holds its value after an abort.
- CMD_START while busy is ignored. CMD_ABORT in IDLE is ignored.
- tx_done outside *_W states is ignored.
- rx_valid and tx_done in the same cycle are both honoured. Example: in LO_W with abort, the count increments, then the state goes to IDLE.
- rst mid-dump: state goes to IDLE, and the abort flag and holding register are cleared. No further pix_req or tx_start is issued.

## Timing
- Reset values: pix_load=0, pix_req=0, tx_start=0, tx_byte=8'h00, busy=0, pix_count=0, done=0.
- All outputs are registered-state decodes, valid in the cycle the state is occupied.
- Start latency: rx_valid (CMD_START) at cycle n -> LOAD at n+1 (pix_load=1, busy=1) -> tx_start with SYNC0 at n+2.
- Pixel path: pix_req at cycle m -> pix_data sampled at m+1 -> tx_start (high byte) at m+2.
- Gap after tx_done:
  - LO_W -> REQ: 3 cycles from tx_done to the next tx_start (REQ, LATCH, HI).
  - HI_W -> LO: 1 cycle.
  - S0_W -> S1: 1 cycle.
  - S1_W -> REQ: 3 cycles.
- Last pixel: tx_done in LO_W at cycle k -> FIN at k+1 (done=1, busy=0) -> IDLE at k+2.
- Exactly FRAME_PIXELS pix_req pulses and 2+2*FRAME_PIXELS tx_start pulses per completed dump.

## Test plan
- Basic dump, FRAME_PIXELS=4, FIFO returning 16'h1234, 16'hABCD, 16'h0001, 16'hFF00; tx model answers tx_done 10 cycles after each tx_start.
  - Required bytes: A5 5A 12 34 AB CD 00 01 FF 00.
  - 4 pix_req, 1 pix_load, 1 done; pix_count=4 after completion; busy low from FIN onward.
- Latency check: rx_valid 'S' at cycle 100 -> pix_load at 101, tx_start/A5 at 102. After the final tx_done at cycle k, done at k+1.
- Abort during HI_W (pixel 2):
  - The high byte completes, then IDLE; no low byte is sent and no done pulse occurs.
  - pix_count=1; a new 'S' then restarts with pix_load and count 0.
- Ignored inputs:
  - 'S' mid-dump: no restart.
  - 'X' and byte 8'h41 in IDLE: no activity.
  - Spurious tx_done in REQ: no state change; byte stream unchanged.
- Reset mid-dump, asserted 1 cycle during LO_W: all outputs return to reset values next cycle; no tx_start until a new 'S'.
- Simultaneous: 'X' on the same cycle as tx_done in LO_W of pixel 3 -> pix_count=3, IDLE next cycle, no pix_req.
